// File: rtl/mux_config_loader.sv
// mux_config_loader: serial configuration loader for a row of switch-box
// input multiplexers. Frames of PAYLOAD selector bits plus an even-parity
// bit are shifted into a shadow register and committed atomically to
// config_out. Code 7 on any selector turns that mux off, so reset loads
// all-ones.
// Optional build macro: MUX_CONFIG_READBACK_EN. When it is defined, the
// shadow is loaded from config_out on cfg_start, and the previous active
// configuration shifts out on cfg_rdbk, MSB first, while the new frame
// shifts in.
module mux_config_loader #(
    parameter int unsigned NUM_MUX = 4,
    parameter int unsigned SEL_W   = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cfg_start,
    input  logic                       cfg_bit,
    input  logic                       cfg_valid,
    output logic                       cfg_ready,
    output logic                       cfg_busy,
    output logic                       cfg_done,
    output logic                       cfg_err,
    output logic [NUM_MUX*SEL_W-1:0]   config_out,
    output logic                       cfg_rdbk
);

    localparam int unsigned PAYLOAD = NUM_MUX * SEL_W;
    localparam int unsigned CNT_W   = $clog2(PAYLOAD + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2,
        COMMIT = 2'd3
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [PAYLOAD-1:0]   shadow;
    logic [PAYLOAD-1:0]   shadow_nxt;
    logic [PAYLOAD-1:0]   config_nxt;
    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     cnt_nxt;
    logic                 par;
    logic                 par_nxt;
    logic                 err_nxt;
    logic                 done_nxt;
    logic                 ready_nxt;
    logic                 busy_nxt;
    logic                 rdbk_nxt;

    // Next-state, datapath and registered-output decode
    always_comb begin
        state_nxt  = state;
        shadow_nxt = shadow;
        config_nxt = config_out;
        cnt_nxt    = cnt;
        par_nxt    = par;
        err_nxt    = cfg_err;
        done_nxt   = 1'b0;

        case (state)
            IDLE: begin
                if (cfg_start) begin
                    state_nxt = SHIFT;
                    cnt_nxt   = '0;
                    par_nxt   = 1'b0;
                    err_nxt   = 1'b0;
`ifdef MUX_CONFIG_READBACK_EN
                    shadow_nxt = config_out;
`endif
                end
            end
            SHIFT: begin
                if (cfg_valid) begin
                    shadow_nxt = {shadow[PAYLOAD-2:0], cfg_bit};
                    par_nxt    = par ^ cfg_bit;
                    cnt_nxt    = cnt + CNT_W'(1);
                    if (cnt == CNT_W'(PAYLOAD - 1)) begin
                        state_nxt = PARITY;
                    end
                end
            end
            PARITY: begin
                if (cfg_valid) begin
                    if ((par ^ cfg_bit) == 1'b0) begin
                        state_nxt = COMMIT;
                    end else begin
                        err_nxt   = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            COMMIT: begin
                config_nxt = shadow;
                done_nxt   = 1'b1;
                state_nxt  = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        ready_nxt = (state_nxt == SHIFT) || (state_nxt == PARITY);
        busy_nxt  = (state_nxt != IDLE);
`ifdef MUX_CONFIG_READBACK_EN
        rdbk_nxt  = (state_nxt == SHIFT) ? shadow_nxt[PAYLOAD-1] : 1'b0;
`else
        rdbk_nxt  = 1'b0;
`endif
    end

    // State, datapath and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            shadow     <= '1;
            config_out <= '1;
            cnt        <= '0;
            par        <= 1'b0;
            cfg_err    <= 1'b0;
            cfg_done   <= 1'b0;
            cfg_ready  <= 1'b0;
            cfg_busy   <= 1'b0;
            cfg_rdbk   <= 1'b0;
        end else begin
            state      <= state_nxt;
            shadow     <= shadow_nxt;
            config_out <= config_nxt;
            cnt        <= cnt_nxt;
            par        <= par_nxt;
            cfg_err    <= err_nxt;
            cfg_done   <= done_nxt;
            cfg_ready  <= ready_nxt;
            cfg_busy   <= busy_nxt;
            cfg_rdbk   <= rdbk_nxt;
        end
    end

endmodule

// File: tb/tb_mux_config_loader.sv
// Testbench for mux_config_loader (NUM_MUX=4, SEL_W=3). It uses table vectors,
// hand-written corner sequences and random frames checked against a frame-level model.
module tb_mux_config_loader;

    localparam int unsigned PAYLOAD = 12;

    logic               clk = 1'b0;
    logic               rst;
    logic               cfg_start;
    logic               cfg_bit;
    logic               cfg_valid;
    logic               cfg_ready;
    logic               cfg_busy;
    logic               cfg_done;
    logic               cfg_err;
    logic [PAYLOAD-1:0] config_out;
    logic               cfg_rdbk;

    int                 checks   = 0;
    int                 failures = 0;
    logic [PAYLOAD-1:0] model_cfg;

    always #5 clk = ~clk;

    mux_config_loader #(.NUM_MUX(4), .SEL_W(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_start  (cfg_start),
        .cfg_bit    (cfg_bit),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_busy   (cfg_busy),
        .cfg_done   (cfg_done),
        .cfg_err    (cfg_err),
        .config_out (config_out),
        .cfg_rdbk   (cfg_rdbk)
    );

    typedef struct {
        logic [11:0] pl;
        logic        pbit;
        int          stall;
        bit          stray;
        logic [11:0] exp_cfg;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Sends one frame (payload MSB-first, then parity) and checks the outcome.
    // exp_lat is the number of negedges after the parity transfer at which cfg_done is seen (-1 = never).
    task automatic do_frame(input string name, input logic [11:0] pl, input logic pbit,
                            input int stall, input bit stray, input logic [11:0] exp_cfg,
                            input logic exp_err, input int exp_lat);
        logic [12:0] bits;
        logic [11:0] rd;
        logic [11:0] exp_rd;
        int          idx;
        int          cyc;
        int          first;
        int          dcnt;
        bit          stray_done;
        bit          held;
        logic        v;
        bits = {pl, pbit};
        rd = '0;
        idx = 0;
        cyc = 0;
        first = -1;
        dcnt = 0;
        stray_done = 1'b0;
        held = 1'b1;
`ifdef MUX_CONFIG_READBACK_EN
        exp_rd = model_cfg;
`else
        exp_rd = '0;
`endif
        @(negedge clk);
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        chk({name, " err_cleared"}, 32'(cfg_err), 32'd0);
        chk({name, " busy"}, 32'(cfg_busy), 32'd1);
        while (idx < 13 && cyc < 300) begin
            case (stall)
                0:       v = 1'b1;
                1:       v = ((cyc % 3) == 0);
                default: v = ($urandom_range(0, 2) != 0);
            endcase
            cfg_valid = v;
            cfg_bit   = v ? bits[12-idx] : 1'($urandom);
            cfg_start = stray && !stray_done && (idx == 5);
            if (cfg_start) stray_done = 1'b1;
            if (config_out !== model_cfg) held = 1'b0;
            if (v && cfg_ready) begin
                if (idx < 12) rd[11-idx] = cfg_rdbk;
                idx++;
            end
            @(negedge clk);
            cyc++;
        end
        cfg_valid = 1'b0;
        cfg_start = 1'b0;
        chk({name, " transfers"}, 32'(idx), 32'd13);
        chk({name, " no_partial"}, 32'(held), 32'd1);
        for (int k = 0; k < 4; k++) begin
            if (cfg_done === 1'b1) begin
                dcnt++;
                if (first < 0) begin
                    first = k;
                    chk({name, " cfg_at_done"}, 32'(config_out), 32'(exp_cfg));
                end
            end
            @(negedge clk);
        end
        chk({name, " done_latency"}, 32'(first), 32'(exp_lat));
        chk({name, " done_pulses"}, 32'(dcnt), (exp_lat >= 0) ? 32'd1 : 32'd0);
        chk({name, " config_out"}, 32'(config_out), 32'(exp_cfg));
        chk({name, " cfg_err"}, 32'(cfg_err), 32'(exp_err));
        chk({name, " idle"}, 32'(cfg_busy), 32'd0);
        chk({name, " rdbk"}, 32'(rd), 32'(exp_rd));
        model_cfg = exp_cfg;
    endtask

    initial begin
        logic [11:0] pl;
        logic        bad;
        rst = 1'b1;
        cfg_start = 1'b0;
        cfg_bit = 1'b0;
        cfg_valid = 1'b0;
        model_cfg = '1;

        // Reset held two cycles
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset config_out", 32'(config_out), 32'hFFF);
        chk("reset busy", 32'(cfg_busy), 32'd0);
        chk("reset ready", 32'(cfg_ready), 32'd0);
        chk("reset err", 32'(cfg_err), 32'd0);
        chk("reset done", 32'(cfg_done), 32'd0);
        rst = 1'b0;

        vecs[0] = '{12'h053, 1'b0, 0, 1'b0, 12'h053, 1'b0, 1};
        vecs[1] = '{12'h053, 1'b1, 0, 1'b0, 12'h053, 1'b1, -1};
        vecs[2] = '{12'h001, 1'b1, 0, 1'b0, 12'h001, 1'b0, 1};
        vecs[3] = '{12'h053, 1'b0, 1, 1'b1, 12'h053, 1'b0, 1};
        vecs[4] = '{12'h800, 1'b0, 0, 1'b0, 12'h053, 1'b1, -1};
        vecs[5] = '{12'hFFF, 1'b0, 2, 1'b0, 12'hFFF, 1'b0, 1};
        vecs[6] = '{12'h5A5, 1'b0, 2, 1'b1, 12'h5A5, 1'b0, 1};

        for (int i = 0; i < 7; i++) begin
            do_frame($sformatf("vec%0d", i), vecs[i].pl, vecs[i].pbit, vecs[i].stall,
                     vecs[i].stray, vecs[i].exp_cfg, vecs[i].exp_err, vecs[i].exp_lat);
            if (i == 3) begin
                chk("vec3 mux0", 32'(config_out[2:0]), 32'd3);
                chk("vec3 mux3", 32'(config_out[11:9]), 32'd0);
            end
        end

        // Reset after five payload bits aborts the frame
        @(negedge clk);
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cfg_valid = 1'b1;
            cfg_bit = 1'($urandom);
            @(negedge clk);
        end
        cfg_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst config_out", 32'(config_out), 32'hFFF);
        chk("midrst busy", 32'(cfg_busy), 32'd0);
        chk("midrst ready", 32'(cfg_ready), 32'd0);
        model_cfg = '1;
        do_frame("after_midrst", 12'h053, 1'b0, 0, 1'b0, 12'h053, 1'b0, 1);

        // Random frames against the frame-level model
        for (int i = 0; i < 40; i++) begin
            pl  = 12'($urandom);
            bad = ($urandom_range(0, 3) == 0);
            do_frame($sformatf("rand%0d", i), pl, (^pl) ^ bad, 2, ($urandom_range(0, 4) == 0),
                     bad ? model_cfg : pl, bad, bad ? -1 : 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
